mux_scan_ctrl: RTL

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

---
 rtl/mux_scan_ctrl_pkg.sv | 14 +
 rtl/mux16to1.sv | 12 +
 rtl/mux_scan_ctrl.sv | 80 ++++++++
 3 files changed

// File: rtl/mux_scan_ctrl_pkg.sv
// Shared widths and FSM encoding for the mux select scanner.
package mux_scan_ctrl_pkg;

  localparam int unsigned MUX_W = 16;
  localparam int unsigned SEL_W = 4;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StScan = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/mux16to1.sv
// 16-to-1 bit multiplexer.
module mux16to1
  import mux_scan_ctrl_pkg::*;
(
  input  logic [MUX_W-1:0] in,
  input  logic [SEL_W-1:0] sel,
  output logic             out
);

  assign out = in[sel];

endmodule

// File: rtl/mux_scan_ctrl.sv
// Walks a 16:1 mux select from 0 up to a programmed last index, holding each
// select for HOLD cycles and strobing bit_valid on the last cycle of each hold.
module mux_scan_ctrl
  import mux_scan_ctrl_pkg::*;
#(
  parameter int unsigned HOLD = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [MUX_W-1:0] data_in,
  input  logic [SEL_W-1:0] last_sel,
  input  logic             abort,
  output logic             busy,
  output logic [SEL_W-1:0] sel,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             done
);

  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(HOLD - 1);

  state_e           state_q;
  logic [MUX_W-1:0] data_q;
  logic [SEL_W-1:0] last_q;
  logic [SEL_W-1:0] sel_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      data_q  <= '0;
      last_q  <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            data_q  <= data_in;
            last_q  <= last_sel;
            sel_q   <= '0;
            cnt_q   <= '0;
            state_q <= StScan;
          end else begin
            state_q <= StIdle;
          end
        end
        StScan: begin
          // abort beats a coincident final strobe, so no done pulse follows
          if (abort) begin
            state_q <= StIdle;
          end else if (cnt_q == HoldLast) begin
            if (sel_q == last_q) begin
              state_q <= StDone;
            end else begin
              sel_q <= sel_q + 1'b1;
              cnt_q <= '0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy      = (state_q == StScan);
  assign bit_valid = (state_q == StScan) && (cnt_q == HoldLast);
  assign done      = (state_q == StDone);
  assign sel       = sel_q;

  mux16to1 u_mux (
    .in  (data_q),
    .sel (sel_q),
    .out (bit_out)
  );

endmodule
